// File: rtl/top_core_pkg.sv
// Shared definitions for the top_core SPI test shell.
// Holds the SPI command codes, the SPI slave FSM state encoding and the
// default byte addresses of the GPIO output and status registers.
package top_core_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [31:0] GPIO_ADDR   = 32'h0000_1000;
  localparam logic [31:0] STATUS_ADDR = 32'h0000_1004;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    DUMMY,
    RDATA,
    IGNORE
  } spi_state_e;

endpackage

// File: rtl/top_core_spi_slave_if.sv
// spi_slave_if: single-lane SPI mode-0 slave oversampled in the clk_i domain.
// Ports:
//   clk_i, rst_ni          system clock, asynchronous active-low reset
//   spi_sclk/spi_cs/spi_sdi raw SPI pins from the host (cs active low)
//   spi_sdo                 serial data out (0 outside the read data phase)
//   req_o/we_o/addr_o/wdata_o  one-cycle access strobe towards the register/memory decode
//   rdata_i                 read data, valid two cycles after a read strobe is raised
module spi_slave_if
  import top_core_pkg::*;
#(
  parameter int unsigned DUMMY_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i
);

  localparam int unsigned MAX_BITS = (DUMMY_CYCLES > 32) ? DUMMY_CYCLES : 32;
  localparam int unsigned CNT_W    = $clog2(MAX_BITS);

  // Synchroniser stages, bit order {sdi, cs, sclk}; cs idles high.
  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic             sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  spi_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      in_sh_q, in_sh_d, rd_sh_q, rd_sh_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic             is_read_q, is_read_d, sdo_q, sdo_d;
  logic             req_q, req_d, we_q, we_d;
  logic             cap1_q, cap1_d, cap2_q, cap2_d;

  logic        sclk_s, cs_s, sdi_s, rise, fall, cs_fall, cs_rise;
  logic [31:0] in_bits;

  assign sclk_s  = sync2_q[0];
  assign cs_s    = sync2_q[1];
  assign sdi_s   = sync2_q[2];
  assign rise    = sclk_s & ~sclk_prev_q;
  assign fall    = ~sclk_s & sclk_prev_q;
  assign cs_fall = ~cs_s & cs_prev_q;
  assign cs_rise = cs_s & ~cs_prev_q;
  assign in_bits = {in_sh_q[30:0], sdi_s};

  always_comb begin
    sync1_d     = {spi_sdi, spi_cs, spi_sclk};
    sync2_d     = sync1_q;
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_sh_d     = in_sh_q;
    rd_sh_d     = rd_sh_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_read_d   = is_read_q;
    sdo_d       = sdo_q;
    req_d       = 1'b0;
    we_d        = 1'b0;
    cap1_d      = 1'b0;
    // Read data appears two cycles after the strobe: strobe flop, then RAM output flop.
    cap2_d      = cap1_q;
    if (cap2_q) rd_sh_d = rdata_i;

    if (cs_rise) begin
      // Deselect aborts everything; a write that has not seen all 72 bits is dropped.
      state_d = IDLE;
      cnt_d   = '0;
      sdo_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (cs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
        end
        CMD: if (rise) begin
          in_sh_d = in_bits;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            cnt_d = '0;
            if (in_bits[7:0] == CMD_WRITE) begin
              state_d   = ADDR;
              is_read_d = 1'b0;
            end else if (in_bits[7:0] == CMD_READ) begin
              state_d   = ADDR;
              is_read_d = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR: if (rise) begin
          in_sh_d = in_bits;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(31)) begin
            cnt_d  = '0;
            addr_d = in_bits;
            if (is_read_q) begin
              state_d = DUMMY;
              req_d   = 1'b1;
              cap1_d  = 1'b1;
            end else begin
              state_d = WDATA;
            end
          end
        end
        WDATA: if (rise) begin
          in_sh_d = in_bits;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(31)) begin
            cnt_d   = '0;
            wdata_d = in_bits;
            req_d   = 1'b1;
            we_d    = 1'b1;
            state_d = IGNORE;
          end
        end
        DUMMY: if (rise) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = RDATA;
          end
        end
        RDATA: begin
          if (fall) begin
            sdo_d   = rd_sh_q[31];
            rd_sh_d = {rd_sh_q[30:0], 1'b0};
          end
          if (rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(31)) begin
              cnt_d   = '0;
              sdo_d   = 1'b0;
              state_d = IGNORE;
            end
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 3'b010;
      sync2_q     <= 3'b010;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_sh_q     <= '0;
      rd_sh_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_read_q   <= 1'b0;
      sdo_q       <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      cap1_q      <= 1'b0;
      cap2_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_sh_q     <= in_sh_d;
      rd_sh_q     <= rd_sh_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_read_q   <= is_read_d;
      sdo_q       <= sdo_d;
      req_q       <= req_d;
      we_q        <= we_d;
      cap1_q      <= cap1_d;
      cap2_q      <= cap2_d;
    end
  end

  assign spi_sdo = sdo_q;
  assign req_o   = req_q;
  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/top_core.sv
// top_core: SoC test shell giving an SPI host word access to a 32-bit memory,
// a GPIO output register and a read-only strap status register.
// Ports:
//   clk_i, rst_ni                 system clock, asynchronous active-low reset
//   fetch_enable_i, en_ifetch_i   core straps, visible through the status register
//   spi_sclk, spi_cs, spi_sdi0..3 SPI inputs (only sdi0 used)
//   spi_mode, spi_sdo0..3         SPI outputs (single lane, only sdo0 active)
//   gpio_o                        GPIO output register
module top_core #(
  parameter int unsigned MEM_WORDS    = 256,
  parameter int unsigned DUMMY_CYCLES = 32,
  parameter logic [31:0] GPIO_ADDR    = top_core_pkg::GPIO_ADDR,
  parameter logic [31:0] STATUS_ADDR  = top_core_pkg::STATUS_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic        en_ifetch_i,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  output logic [1:0]  spi_mode,
  input  logic        spi_sdi0,
  input  logic        spi_sdi1,
  input  logic        spi_sdi2,
  input  logic        spi_sdi3,
  output logic        spi_sdo0,
  output logic        spi_sdo1,
  output logic        spi_sdo2,
  output logic        spi_sdo3,
  output logic [31:0] gpio_o
);
  import top_core_pkg::*;

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  spi_slave_if #(
    .DUMMY_CYCLES(DUMMY_CYCLES)
  ) u_spi (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .spi_sclk(spi_sclk),
    .spi_cs  (spi_cs),
    .spi_sdi (spi_sdi0),
    .spi_sdo (spi_sdo0),
    .req_o   (bus_req),
    .we_o    (bus_we),
    .addr_o  (bus_addr),
    .wdata_o (bus_wdata),
    .rdata_i (bus_rdata)
  );

  logic          unused_sdi;
  logic          mem_hit;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   mem_rd_q;
  logic [31:0]   gpio_q, gpio_d, reg_rd_q, reg_rd_d;
  logic          rd_is_mem_q, rd_is_mem_d;

  assign unused_sdi = ^{spi_sdi1, spi_sdi2, spi_sdi3};
  assign mem_hit    = (bus_addr < MEM_BYTES);
  assign mem_idx    = bus_addr[AW+1:2];

  // Memory contents survive reset, so this array lives outside the reset domain.
  always_ff @(posedge clk_i) begin
    if (bus_req && bus_we && mem_hit) mem[mem_idx] <= bus_wdata;
    if (bus_req && !bus_we) mem_rd_q <= mem[mem_idx];
  end

  // Register-side read data is captured alongside the RAM read so both arrive together.
  always_comb begin
    gpio_d      = gpio_q;
    reg_rd_d    = reg_rd_q;
    rd_is_mem_d = rd_is_mem_q;
    if (bus_req && bus_we && !mem_hit && (bus_addr == GPIO_ADDR)) gpio_d = bus_wdata;
    if (bus_req && !bus_we) begin
      rd_is_mem_d = mem_hit;
      if (bus_addr == GPIO_ADDR)        reg_rd_d = gpio_q;
      else if (bus_addr == STATUS_ADDR) reg_rd_d = {30'b0, en_ifetch_i, fetch_enable_i};
      else                              reg_rd_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gpio_q      <= '0;
      reg_rd_q    <= '0;
      rd_is_mem_q <= 1'b0;
    end else begin
      gpio_q      <= gpio_d;
      reg_rd_q    <= reg_rd_d;
      rd_is_mem_q <= rd_is_mem_d;
    end
  end

  assign bus_rdata = rd_is_mem_q ? mem_rd_q : reg_rd_q;
  assign gpio_o    = gpio_q;
  assign spi_mode  = 2'b00;
  assign spi_sdo1  = 1'b0;
  assign spi_sdo2  = 1'b0;
  assign spi_sdo3  = 1'b0;

endmodule

// File: tb/tb_top_core.sv
module tb_top_core;
  import top_core_pkg::*;

  localparam int HALF = 60;  // sclk half period: 6 clk_i periods

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fe = 1'b0, ei = 1'b0;
  logic        sclk = 1'b0, cs = 1'b1;
  logic        sdi0 = 1'b0, sdi1 = 1'b0, sdi2 = 1'b0, sdi3 = 1'b0;
  logic [1:0]  spi_mode;
  logic        sdo0, sdo1, sdo2, sdo3;
  logic [31:0] gpio;

  always #5 clk = ~clk;

  top_core dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .fetch_enable_i(fe),
    .en_ifetch_i   (ei),
    .spi_sclk      (sclk),
    .spi_cs        (cs),
    .spi_mode      (spi_mode),
    .spi_sdi0      (sdi0),
    .spi_sdi1      (sdi1),
    .spi_sdi2      (sdi2),
    .spi_sdi3      (sdi3),
    .spi_sdo0      (sdo0),
    .spi_sdo1      (sdo1),
    .spi_sdo2      (sdo2),
    .spi_sdo3      (sdo3),
    .gpio_o        (gpio)
  );

  // kind 0: sdo must stay 0 for the whole frame; 1: read word expected; 2: no check
  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  task automatic expect_frame(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] addr,
                           input logic [31:0] data, input int nbits, input bit end_cs);
    logic [103:0] bits;
    bits = {cmd, addr, data, 32'h0};
    cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      sdi0 = bits[103-i];
      #HALF sclk = 1'b1;
      #HALF sclk = 1'b0;
    end
    sdi0 = 1'b0;
    if (end_cs) begin
      #HALF cs = 1'b1;
      #(2*HALF);
    end
  endtask

  task automatic do_write(input string name, input logic [31:0] addr, input logic [31:0] data);
    expect_frame(0, 32'h0, name);
    spi_frame(CMD_WRITE, addr, data, 72, 1'b1);
  endtask

  task automatic do_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
    expect_frame(1, exp, name);
    spi_frame(CMD_READ, addr, 32'h0, 104, 1'b1);
  endtask

  // Monitor: snoops each cs frame, collects sdo0 on sclk rises, checks at cs release.
  initial begin
    int          nb;
    logic        pre_or;
    logic [31:0] data;
    exp_t        e;
    forever begin
      @(negedge cs);
      nb = 0;
      pre_or = 1'b0;
      data = 32'h0;
      forever begin
        @(posedge sclk or posedge cs);
        if (cs) break;
        nb++;
        if (nb <= 72) pre_or = pre_or | sdo0;
        else if (nb <= 104) data = {data[30:0], sdo0};
      end
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got frame of %0d bits expected none", nb);
      end else begin
        e = sb.pop_front();
        if (e.kind == 0) begin
          check({e.name, "_sdo_quiet"}, {31'b0, pre_or}, 32'h0);
        end else if (e.kind == 1) begin
          check({e.name, "_sdo_pre"}, {31'b0, pre_or}, 32'h0);
          check(e.name, data, e.val);
        end
      end
    end
  end

  initial begin
    #23;
    check("rst_gpio", gpio, 32'h0);
    check("rst_sdo", {28'h0, sdo3, sdo2, sdo1, sdo0}, 32'h0);
    check("rst_mode", {30'h0, spi_mode}, 32'h0);
    rst_n = 1'b1;
    #50;

    // 1: memory write then read
    do_write("t1_wr", 32'd100, 32'd100);
    #100;
    do_read("t1_rd_100", 32'd100, 32'd100);

    // 2: GPIO write committed before cs is released
    expect_frame(0, 32'h0, "t2_wr_gpio");
    spi_frame(CMD_WRITE, GPIO_ADDR, 32'hA5A5_0F0F, 72, 1'b0);
    check("t2_gpio_commit", gpio, 32'hA5A5_0F0F);
    #HALF cs = 1'b1;
    #(2*HALF);
    do_read("t2_rd_gpio", GPIO_ADDR, 32'hA5A5_0F0F);

    // 3: status straps
    fe = 1'b1; ei = 1'b0;
    do_read("t3_status_01", STATUS_ADDR, 32'h0000_0001);
    ei = 1'b1;
    do_read("t3_status_11", STATUS_ADDR, 32'h0000_0003);

    // 4: aborted write leaves memory untouched
    do_write("t4_wr", 32'd8, 32'h0000_1234);
    expect_frame(0, 32'h0, "t4_abort");
    spi_frame(CMD_WRITE, 32'd8, 32'h0000_FFFF, 50, 1'b1);
    do_read("t4_rd_8", 32'd8, 32'h0000_1234);

    // 5: unknown command and unmapped read
    expect_frame(0, 32'h0, "t5_cmd55");
    spi_frame(8'h55, GPIO_ADDR, 32'hDEAD_BEEF, 72, 1'b1);
    check("t5_gpio_kept", gpio, 32'hA5A5_0F0F);
    do_read("t5_rd_8000", 32'h0000_8000, 32'h0);

    // memory edges, byte-offset aliasing, out-of-range write
    do_write("b_wr_0", 32'h0, 32'h1111_1111);
    do_write("b_wr_3ff", 32'h3FF, 32'h3C3C_5A5A);
    do_write("b_wr_400", 32'h400, 32'h2222_2222);
    do_read("b_rd_400", 32'h400, 32'h0);
    do_read("b_rd_0", 32'h0, 32'h1111_1111);
    do_read("b_rd_3fc", 32'h3FC, 32'h3C3C_5A5A);
    do_read("b_rd_1008", 32'h1008, 32'h0);

    // 6: reset during read data phase (bit 24 of A5A50F0F is being driven)
    expect_frame(2, 32'h0, "t6_reset_frame");
    spi_frame(CMD_READ, GPIO_ADDR, 32'h0, 80, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_sdo", {31'h0, sdo0}, 32'h0);
    check("t6_rst_gpio", gpio, 32'h0);
    #HALF cs = 1'b1;
    #100;
    rst_n = 1'b1;
    #100;
    do_read("t6_rd_100", 32'd100, 32'd100);
    do_read("t6_rd_gpio", GPIO_ADDR, 32'h0);

    #200;
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
